// File: rtl/aes_round_pkg.sv
// Shared AES round definitions: op encoding, forward S-box and GF(2^8) doubling.
// The T-tables are derived from SBOX with xtime rather than stored.
package aes_round_pkg;

   typedef enum logic [1:0] {
      OP_MID   = 2'd0,
      OP_FINAL = 2'd1,
      OP_INIT  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   // Element 0 is the most significant byte, so SBOX[x] reads in table order.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_col_lookup.sv
// Combinational S-box / T-table lookup for the four bytes of one shifted column.
// tv[i] is Ti[byte i]; sb[i] is S[byte i]; index 0 is the top row (MSB byte).
module aes_col_lookup
   import aes_round_pkg::*;
(
   input  logic [31:0]      col,
   output logic [0:3][31:0] tv,
   output logic [0:3][7:0]  sb
);

   logic [7:0]  s1;
   logic [7:0]  s2;
   logic [7:0]  s3;
   logic [31:0] t0;
   logic [63:0] dbl;

   always_comb begin
      tv  = '0;
      sb  = '0;
      s1  = '0;
      s2  = '0;
      s3  = '0;
      t0  = '0;
      dbl = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         s1    = SBOX[col[31-8*i -: 8]];
         s2    = xtime(s1);
         s3    = s2 ^ s1;
         t0    = {s2, s1, s1, s3};
         // Ti is T0 rotated right by i bytes.
         dbl   = {t0, t0} >> (8*i);
         sb[i] = s1;
         tv[i] = dbl[31:0];
      end
   end

endmodule

// File: rtl/aes_round_pipe.sv
// Pipelined AES encryption round (MID / FINAL / optional INIT) with valid/ready and tag sideband.
// Define AES_ROUND_INIT_EN to enable op 2 (AddRoundKey only); otherwise op 2 is reserved.
module aes_round_pipe
   import aes_round_pkg::*;
#(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [127:0]     in_state,
   input  logic [127:0]     in_key,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_state,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   logic             out_load;
   logic             stage_load;
   logic             in_fire;
   logic             adv;
   logic             out_valid_q;
   logic             err_q;
   logic [127:0]     r_state;
   logic [127:0]     r_key;
   logic [1:0]       r_op;
   logic [TAG_W-1:0] r_tag;
   logic             r_valid;

   assign out_load = !out_valid_q | out_ready;
   assign in_ready = !rst & !flush & stage_load;
   assign in_fire  = in_valid & in_ready;

   generate
      if (PIPE == 2) begin : g_pipe2
         logic             s1_valid;
         logic [127:0]     s1_state;
         logic [127:0]     s1_key;
         logic [1:0]       s1_op;
         logic [TAG_W-1:0] s1_tag;

         assign stage_load = !s1_valid | out_load;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)             s1_valid <= 1'b0;
            else if (flush)      s1_valid <= 1'b0;
            else if (stage_load) s1_valid <= in_fire;
         end

         always_ff @(posedge clk) begin
            if (in_fire) begin
               s1_state <= in_state;
               s1_key   <= in_key;
               s1_op    <= in_op;
               s1_tag   <= in_tag;
            end
         end

         assign r_state = s1_state;
         assign r_key   = s1_key;
         assign r_op    = s1_op;
         assign r_tag   = s1_tag;
         assign r_valid = s1_valid;
      end else if (PIPE == 1) begin : g_pipe1
         assign stage_load = out_load;
         assign r_state    = in_state;
         assign r_key      = in_key;
         assign r_op       = in_op;
         assign r_tag      = in_tag;
         assign r_valid    = in_fire;
      end else begin : g_bad_pipe
         $error("aes_round_pipe: PIPE must be 1 or 2");
      end
   endgenerate

   // ShiftRows folded into the lookup inputs: row r of column j comes from column j+r.
   logic [0:3][31:0]       col_in;
   logic [0:3][0:3][31:0]  tv;
   logic [0:3][0:3][7:0]   sb;

   always_comb begin
      col_in = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            col_in[j][31-8*r -: 8] = r_state[127-8*(4*((j+r)%4)+r) -: 8];
         end
      end
   end

   generate
      for (genvar j = 0; j < 4; j++) begin : g_col
         aes_col_lookup u_lookup (
            .col (col_in[j]),
            .tv  (tv[j]),
            .sb  (sb[j])
         );
      end
   endgenerate

   logic [127:0] res;
   logic         res_err;

   always_comb begin
      res     = r_state;
      res_err = 1'b0;
      case (op_e'(r_op))
         OP_MID: begin
            for (int unsigned j = 0; j < 4; j++) begin
               res[127-32*j -: 32] = tv[j][0] ^ tv[j][1] ^ tv[j][2] ^ tv[j][3]
                                   ^ r_key[127-32*j -: 32];
            end
         end
         OP_FINAL: begin
            for (int unsigned j = 0; j < 4; j++) begin
               res[127-32*j -: 32] = sb[j] ^ r_key[127-32*j -: 32];
            end
         end
`ifdef AES_ROUND_INIT_EN
         OP_INIT: res = r_state ^ r_key;
`endif
         default: res_err = 1'b1;
      endcase
   end

   assign adv = r_valid & out_load & !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_state   <= '0;
         out_tag     <= '0;
         err_q       <= 1'b0;
      end else begin
         if (flush)         out_valid_q <= 1'b0;
         else if (out_load) out_valid_q <= r_valid;
         if (adv) begin
            out_state <= res;
            out_tag   <= r_tag;
            err_q     <= res_err;
         end
      end
   end

   assign out_valid = out_valid_q;
   // Gated by valid so the error flag never outlives its beat.
   assign out_err   = err_q & out_valid_q;

endmodule

// File: tb/tb_aes_round_pipe.sv
// Scoreboard bench for aes_round_pipe: directed FIPS-197 vectors, backpressure, flush and async reset.
module tb_aes_round_pipe;

   localparam int unsigned TAG_W = 4;
   localparam int unsigned PIPE  = 2;

   localparam logic [127:0] MID_ST  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] MID_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] MID_EXP = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] FIN_ST  = 128'heb40f21e592e38848ba113e71bc342d2;
   localparam logic [127:0] FIN_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIN_EXP = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] INI_ST  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] INI_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`ifdef AES_ROUND_INIT_EN
   localparam logic [127:0] INI_EXP = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic         INI_ERR = 1'b0;
`else
   localparam logic [127:0] INI_EXP = INI_ST;
   localparam logic         INI_ERR = 1'b1;
`endif
   localparam logic [127:0] RSV_ST  = 128'h00112233445566778899aabbccddeeff;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [127:0]     in_state;
   logic [127:0]     in_key;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_state;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   aes_round_pipe #(.TAG_W(TAG_W), .PIPE(PIPE)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_state  (in_state),
      .in_key    (in_key),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_tag   (out_tag),
      .out_err   (out_err)
   );

   typedef struct {
      logic [127:0]     st;
      logic [TAG_W-1:0] tag;
      logic             err;
      int               acc;
      bit               lat;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   bp_on  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // out_ready pattern 1,0,0,1 while backpressure is enabled
   initial begin
      int k;
      logic [3:0] pat;
      k   = 0;
      pat = 4'b1001;
      forever begin
         @(posedge clk);
         #1;
         if (bp_on) begin
            out_ready = pat[3 - (k % 4)];
            k++;
         end
      end
   end

   // monitor: pop and compare on each output transfer, and check holds during stalls
   initial begin
      exp_t             e;
      bit               prev_stall;
      logic [127:0]     held_st;
      logic [TAG_W-1:0] held_tag;
      logic             held_err;
      prev_stall = 0;
      held_st    = '0;
      held_tag   = '0;
      held_err   = 1'b0;
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            prev_stall = 0;
            continue;
         end
         if (prev_stall) begin
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_state", out_state, held_st);
            chk("hold_tag", 128'(out_tag), 128'(held_tag));
            chk1("hold_err", out_err, held_err);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got tag %h state %h expected no beat", out_tag, out_state);
            end else begin
               e = sbq.pop_front();
               chk("out_state", out_state, e.st);
               chk("out_tag", 128'(out_tag), 128'(e.tag));
               chk1("out_err", out_err, e.err);
               if (e.lat) chk("latency", 128'(cyc - e.acc), 128'(PIPE));
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         held_st    = out_state;
         held_tag   = out_tag;
         held_err   = out_err;
      end
   end

   task automatic send(input logic [1:0] op, input logic [127:0] st, input logic [127:0] key,
                       input int tag, input logic [127:0] exp_st, input logic exp_err,
                       input bit track, input bit lat);
      exp_t e;
      in_valid = 1'b1;
      in_op    = op;
      in_state = st;
      in_key   = key;
      in_tag   = TAG_W'(tag);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            if (track) begin
               e = '{exp_st, TAG_W'(tag), exp_err, cyc, lat};
               sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready for tag %0d expected accept within 200 cycles", tag);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 100; n++) begin
         if (sbq.size() == 0) break;
         @(posedge clk);
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d beats outstanding expected 0", sbq.size());
         sbq.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_state  = '0;
      in_key    = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      #1;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_out_err", out_err, 1'b0);
      chk("rst_out_state", out_state, '0);
      chk("rst_out_tag", 128'(out_tag), '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk1("release_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // directed rounds, each with an exact latency check
      send(2'd0, MID_ST, MID_KEY, 1, MID_EXP, 1'b0, 1, 1);
      drain();
      send(2'd1, FIN_ST, FIN_KEY, 2, FIN_EXP, 1'b0, 1, 1);
      drain();
      send(2'd2, INI_ST, INI_KEY, 3, INI_EXP, INI_ERR, 1, 1);
      drain();
      // reserved op then a clean beat: err must apply to the reserved beat only
      send(2'd3, RSV_ST, MID_KEY, 4, RSV_ST, 1'b1, 1, 0);
      send(2'd0, MID_ST, MID_KEY, 5, MID_EXP, 1'b0, 1, 0);
      drain();

      // backpressure: 8 back-to-back beats, tags 0..7
      bp_on = 1;
      for (int i = 0; i < 8; i++) begin
         case (i % 4)
            0: send(2'd0, MID_ST, MID_KEY, i, MID_EXP, 1'b0, 1, 0);
            1: send(2'd1, FIN_ST, FIN_KEY, i, FIN_EXP, 1'b0, 1, 0);
            2: send(2'd2, INI_ST, INI_KEY, i, INI_EXP, INI_ERR, 1, 0);
            default: send(2'd3, RSV_ST ^ 128'(i), FIN_KEY, i, RSV_ST ^ 128'(i), 1'b1, 1, 0);
         endcase
      end
      drain();
      bp_on     = 0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // flush with two beats in flight and no downstream acceptance
      out_ready = 1'b0;
      send(2'd0, MID_ST, MID_KEY, 8, MID_EXP, 1'b0, 0, 0);
      send(2'd1, FIN_ST, FIN_KEY, 9, FIN_EXP, 1'b0, 0, 0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_tag   = TAG_W'(10);
      @(negedge clk);
      chk1("flush_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("flush_out_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(2'd0, MID_ST, MID_KEY, 11, MID_EXP, 1'b0, 1, 1);
      drain();

      // flush together with out_ready: the head beat is delivered, the other dropped
      out_ready = 1'b0;
      send(2'd1, FIN_ST, FIN_KEY, 12, FIN_EXP, 1'b0, 1, 0);
      send(2'd0, MID_ST, MID_KEY, 13, MID_EXP, 1'b0, 0, 0);
      flush     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk1("flush_rdy_out_valid", out_valid, 1'b0);
      drain();

      // async reset between edges with the pipe full
      out_ready = 1'b0;
      send(2'd0, MID_ST, MID_KEY, 14, MID_EXP, 1'b0, 0, 0);
      send(2'd1, FIN_ST, FIN_KEY, 15, FIN_EXP, 1'b0, 0, 0);
      @(negedge clk);
      chk1("full_in_ready", in_ready, 1'b0);
      chk1("full_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk1("arst_out_valid", out_valid, 1'b0);
      chk1("arst_out_err", out_err, 1'b0);
      chk1("arst_in_ready", in_ready, 1'b0);
      chk("arst_out_state", out_state, '0);
      #3;
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      chk1("arst_release_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      send(2'd2, INI_ST, INI_KEY, 6, INI_EXP, INI_ERR, 1, 1);
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_round_pipe.md
# aes_round_pipe

Pipelined, parametrised AES encryption round unit with a valid/ready handshake. It performs a middle round (SubBytes, ShiftRows, MixColumns, AddRoundKey) or a final round (no MixColumns), selected per beat. It accepts one beat per cycle at full throughput and passes a sideband tag through with each beat. It replaces the fixed two-cycle middle and final round blocks inside the cipher datapath, sitting between the key-expansion feed and the round-iteration controller.

## Interface
- `TAG_W`, default 4: width of the sideband tag carried alongside each beat (≥1).
- `PIPE`, default 2: register stages, either 1 or 2.
  - 1: combinational round feeding an output register.
  - 2: input register, then combinational round, then output register.
  - Any other value is a elaboration error.
- `clk` in 1: the single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous drop of all in-flight beats.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: unit can accept a beat.
- `in_op` in 2: 0 = MID, 1 = FINAL, 2 = INIT (only under the macro), 3 = reserved.
- `in_state` in 128: state, column 0 in bits 127:96, byte 0 in MSB.
- `in_key` in 128: round key, same packing as `in_state`.
- `in_tag` in TAG_W: sideband tag, returned unmodified.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_state` out 128: round result.
- `out_tag` out TAG_W: tag of the beat on the output.
- `out_err` out 1: the beat carried a reserved/disabled op.

## Operation
- A beat transfers on input when `in_valid & in_ready` and on output when `out_valid & out_ready`.
- **MID** result for column j: z_j = T0[s_j.b0] ^ T1[s_{j+1}.b1] ^ T2[s_{j+2}.b2] ^ T3[s_{j+3}.b3] ^ k_j, indices mod 4.
- **FINAL** result: z_j = {S[s_j.b0], S[s_{j+1}.b1], S[s_{j+2}.b2], S[s_{j+3}.b3]} ^ k_j.
- **INIT** result: state ^ key, with no substitution.
- **Reserved op, or INIT with the macro absent:**
  - `out_state` = `in_state` unchanged.
  - `out_err` = 1 for that beat only.
- Each stage holds a valid bit. A stage loads when it is empty or its contents are leaving in the same cycle.
  - Output stage may load when `!out_valid | out_ready`.
  - `in_ready` = input-stage-may-load (PIPE=2) or output-stage-may-load (PIPE=1).
  - `in_ready` is combinational from `out_ready` and the valid bits; there is no combinational path from `in_valid`.
- Data and tag registers load only on an accepted transfer. They do not need reset, but `out_state` and `out_tag` must be 0 after reset for clean waveforms.
- **flush:** clears all valid bits on the next edge.
  - Beats accepted in the flush cycle are dropped.
  - `in_ready` is forced to 0 during the flush cycle.
- **Reset:** all valid bits are 0 and `out_err` = 0 immediately on `rst` assertion. Reset mid-stream drops every in-flight beat, with no partial output.
- Ordering is strictly FIFO; tags never reorder.

## Timing
- Latency from input accept to `out_valid` is PIPE cycles, when there is no backpressure.
- Throughput is one beat per cycle while `out_ready` = 1.
- **Stall:** with `out_ready` = 0 the unit holds at most PIPE beats, and `in_ready` falls once all stages are full.
  - Output is stable while `out_valid & !out_ready`: state, tag and err are all held.
- **Simultaneous accept and release on a full pipe:** both transfers occur and no bubble is inserted.
- **Simultaneous flush and `out_ready`:** the output beat counts as delivered. The downstream sees it accepted and the valid bit still clears.
- Reset values:
  - `in_ready`: 0 while `rst` is high, and 1 on the first cycle after release.
  - `out_valid`: 0.
  - `out_err`: 0.
  - `out_state`: 0.
  - `out_tag`: 0.

## Configuration
- `AES_ROUND_INIT_EN` defined: op 2 performs the INIT AddRoundKey-only round, with `out_err` = 0.
- `AES_ROUND_INIT_EN` undefined: op 2 is treated as reserved, giving pass-through with `out_err` = 1. The INIT XOR path is not synthesised.

## Structure
- Package `aes_round_pkg` holds:
  - The op enum `OP_MID`/`OP_FINAL`/`OP_INIT`/`OP_RSVD`.
  - The 256×8 S-box constant.
  - The xtime function used to derive the T-tables.
- Sub-module `aes_col_lookup`: combinational lookup for one 32-bit column.
  - Outputs four 32-bit T-values and four S-bytes.
  - Instantiated 4 times.
  - The parent selects between the MID and FINAL combine and registers the result.

## Test plan
- **MID, FIPS-197 App. B round 1:**
  - Stimulus: state 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605.
  - Response: out_state a49c7ff2689f352b6b5bea43026a5049 after PIPE cycles.
- **FINAL, App. B round 10:**
  - Stimulus: state eb40f21e592e38848ba113e71bc342d2, key d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Response: 3925841d02dc09fbdc118597196a0b32.
- **INIT:**
  - Stimulus: state 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response with the macro: 193de3bea0f4e22b9ac68d2ae9f84808, err 0.
  - Response without the macro: input echoed, err 1.
- **Backpressure:**
  - Stimulus: 8 back-to-back beats with tags 0–7, `out_ready` toggled 1,0,0,1 repeating.
  - Response: all 8 are emitted in tag order, with output held stable during stalls and no beat lost or duplicated.
- **Flush:** a flush mid-stream with 2 beats in flight produces no output for them. The next accepted beat emerges after exactly PIPE cycles.
- **Async reset:** `rst` is pulsed between clock edges with the pipe full. `out_valid` drops immediately, and the first beat after release appears PIPE cycles after accept.
